fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 172 +++++++++++++++++
 tb/tb_fetch_unit.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit -- instruction fetch sequencer.
//
// Waits in IDLE for start, then reads one 16-bit instruction word from the
// instruction memory at the current PC. Each completed read updates the
// instruction register and advances the PC by one. The PC wraps from 1023
// to 0. In EXEC, the control unit chooses what happens next: halt stops the
// sequencer, branch loads a new PC and fetches again, and next fetches the
// following word.
//
// Optional feature: define FETCH_TIMEOUT_EN to bound the wait for mem_ack.
// The sequencer then enters ERROR and raises err once TIMEOUT cycles without
// an ack have been counted. Without the macro, FETCH waits forever and err is
// tied low.
//
// Parameters:
//   RESET_PC    PC value loaded by RESET
//   TIMEOUT     ack-less FETCH cycles tolerated (FETCH_TIMEOUT_EN only)
// Ports:
//   CLK, RESET            clock, synchronous active-high reset
//   start                 leave IDLE and begin fetching
//   mem_req/mem_addr      memory read request / address (always equals pc)
//   mem_rdata/mem_ack     read data / read-complete strobe
//   ir_data/ir_w          instruction register data / one-cycle write enable
//   next/branch/halt      control unit requests (used in EXEC only)
//   branch_addr           branch target
//   pc                    program counter
//   state_o               IDLE=0 FETCH=1 EXEC=2 HALTED=3 ERROR=4
//   err                   fetch timeout flag
// ---------------------------------------------------------------------------
module fetch_unit #(
    parameter logic [9:0] RESET_PC = 10'd0,
    parameter int         TIMEOUT  = 15
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        start,
    output logic        mem_req,
    output logic [9:0]  mem_addr,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ack,
    output logic [15:0] ir_data,
    output logic        ir_w,
    input  logic        next,
    input  logic        branch,
    input  logic [9:0]  branch_addr,
    input  logic        halt,
    output logic [9:0]  pc,
    output logic [2:0]  state_o,
    output logic        err
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_EXEC   = 3'd2,
        S_HALTED = 3'd3,
        S_ERROR  = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [9:0]  pc_q, pc_d;
    logic [15:0] ir_data_q, ir_data_d;
    logic        ir_w_q, ir_w_d;
    logic        mem_req_q, mem_req_d;

`ifdef FETCH_TIMEOUT_EN
    // One spare bit so the count can hold TIMEOUT itself without wrapping.
    localparam int CW = $clog2(TIMEOUT + 2);
    logic [CW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic          err_q, err_d;
`endif

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_data_d = ir_data_q;
        ir_w_d    = 1'b0;
`ifdef FETCH_TIMEOUT_EN
        tmo_cnt_d = tmo_cnt_q;
        err_d     = err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_FETCH;
`ifdef FETCH_TIMEOUT_EN
                    tmo_cnt_d = '0;
`endif
                end
            end
            S_FETCH: begin
                if (mem_ack) begin
                    ir_data_d = mem_rdata;
                    ir_w_d    = 1'b1;
                    pc_d      = pc_q + 10'd1;   // natural 10-bit wrap
                    state_d   = S_EXEC;
                end
`ifdef FETCH_TIMEOUT_EN
                else if (tmo_cnt_q == CW'(TIMEOUT)) begin
                    state_d = S_ERROR;
                    err_d   = 1'b1;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
`endif
            end
            S_EXEC: begin
                // Priority: halt > branch > next; no request holds.
                if (halt) begin
                    state_d = S_HALTED;
                end else if (branch) begin
                    pc_d    = branch_addr;
                    state_d = S_FETCH;
`ifdef FETCH_TIMEOUT_EN
                    tmo_cnt_d = '0;
`endif
                end else if (next) begin
                    state_d = S_FETCH;
`ifdef FETCH_TIMEOUT_EN
                    tmo_cnt_d = '0;
`endif
                end
            end
            S_HALTED, S_ERROR: begin
                state_d = state_q;   // only RESET leaves these
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // Registered request: high exactly while the state is FETCH.
        mem_req_d = (state_d == S_FETCH);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= S_IDLE;
            pc_q      <= RESET_PC;
            ir_data_q <= 16'd0;
            ir_w_q    <= 1'b0;
            mem_req_q <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
            tmo_cnt_q <= '0;
            err_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_data_q <= ir_data_d;
            ir_w_q    <= ir_w_d;
            mem_req_q <= mem_req_d;
`ifdef FETCH_TIMEOUT_EN
            tmo_cnt_q <= tmo_cnt_d;
            err_q     <= err_d;
`endif
        end
    end

    assign mem_req  = mem_req_q;
    assign mem_addr = pc_q;
    assign pc       = pc_q;
    assign ir_data  = ir_data_q;
    assign ir_w     = ir_w_q;
    assign state_o  = state_q;
`ifdef FETCH_TIMEOUT_EN
    assign err      = err_q;
`else
    assign err      = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit -- self-checking bench for fetch_unit.
// A directed vector table, hand-written corner sequences (reset during
// FETCH, reset raised between edges, timeout/indefinite wait) and a random
// run, all checked against a behavioural model of the sequencer rules.
// ---------------------------------------------------------------------------
module tb_fetch_unit;

    localparam logic [9:0] RP  = 10'd3;
    localparam int         TMO = 15;

    localparam int ST_IDLE = 0, ST_FETCH = 1, ST_EXEC = 2, ST_HALT = 3, ST_ERR = 4;

    logic        CLK = 1'b0;
    logic        RESET, start, mem_ack, next, branch, halt;
    logic [15:0] mem_rdata;
    logic [9:0]  branch_addr;
    logic        mem_req, ir_w, err;
    logic [9:0]  mem_addr, pc;
    logic [15:0] ir_data;
    logic [2:0]  state_o;

    int n_checks = 0;
    int n_fail   = 0;

    fetch_unit #(.RESET_PC(RP), .TIMEOUT(TMO)) dut (
        .CLK(CLK), .RESET(RESET), .start(start),
        .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .ir_data(ir_data), .ir_w(ir_w),
        .next(next), .branch(branch), .branch_addr(branch_addr),
        .halt(halt), .pc(pc), .state_o(state_o), .err(err)
    );

    always #5 CLK = ~CLK;

    // ---------------- behavioural model ----------------
    int m_st, m_pc, m_ir, m_irw, m_cnt, m_err;

    task automatic model_edge();
        if (RESET) begin
            m_st = ST_IDLE; m_pc = RP; m_ir = 0; m_irw = 0; m_cnt = 0; m_err = 0;
            return;
        end
        m_irw = 0;
        if (m_st == ST_IDLE) begin
            if (start) begin m_st = ST_FETCH; m_cnt = 0; end
        end else if (m_st == ST_FETCH) begin
            if (mem_ack) begin
                m_ir = mem_rdata; m_irw = 1; m_pc = (m_pc + 1) % 1024; m_st = ST_EXEC;
            end else begin
`ifdef FETCH_TIMEOUT_EN
                if (m_cnt >= TMO) begin m_st = ST_ERR; m_err = 1; end
                else m_cnt++;
`endif
            end
        end else if (m_st == ST_EXEC) begin
            if (halt) m_st = ST_HALT;
            else if (branch) begin m_pc = branch_addr; m_st = ST_FETCH; m_cnt = 0; end
            else if (next) begin m_st = ST_FETCH; m_cnt = 0; end
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_model(input string tag);
        chk({tag, ".state"},   state_o,  m_st);
        chk({tag, ".pc"},      pc,       m_pc);
        chk({tag, ".addr"},    mem_addr, m_pc);
        chk({tag, ".ir_data"}, ir_data,  m_ir);
        chk({tag, ".ir_w"},    ir_w,     m_irw);
        chk({tag, ".mem_req"}, mem_req,  (m_st == ST_FETCH) ? 1 : 0);
        chk({tag, ".err"},     err,      m_err);
    endtask

    // One clock: model sees the inputs that the DUT samples at this edge.
    task automatic step(input string tag);
        model_edge();
        @(posedge CLK);
        #1;
        chk_model(tag);
    endtask

    task automatic idle_inputs();
        RESET = 0; start = 0; mem_ack = 0; next = 0; branch = 0; halt = 0;
        mem_rdata = 16'h0; branch_addr = 10'h0;
    endtask

    task automatic do_reset(input string tag);
        idle_inputs();
        RESET = 1;
        step(tag);
        RESET = 0;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        st, ack, nx, br, hl;
        logic [15:0] rdata;
        logic [9:0]  baddr;
        int          e_st;
        int          e_pc;
        logic        e_irw;
        logic [15:0] e_ir;
    } vec_t;

    vec_t tbl [12];

    initial begin
        //          st ack nx br hl  rdata     baddr    state     pc      irw ir
        tbl[0]  = '{1, 0, 0, 0, 0, 16'h0000, 10'h000, ST_FETCH, RP,     0, 16'h0000};
        tbl[1]  = '{0, 1, 0, 0, 0, 16'hA5C3, 10'h000, ST_EXEC,  RP + 1, 1, 16'hA5C3};
        tbl[2]  = '{0, 1, 0, 0, 0, 16'h9999, 10'h000, ST_EXEC,  RP + 1, 0, 16'hA5C3};
        tbl[3]  = '{1, 0, 1, 0, 0, 16'h0000, 10'h000, ST_FETCH, RP + 1, 0, 16'hA5C3};
        tbl[4]  = '{0, 0, 1, 1, 1, 16'h1234, 10'h111, ST_FETCH, RP + 1, 0, 16'hA5C3};
        tbl[5]  = '{0, 1, 0, 0, 0, 16'h0F0F, 10'h000, ST_EXEC,  RP + 2, 1, 16'h0F0F};
        tbl[6]  = '{0, 0, 1, 1, 0, 16'h0000, 10'h2F0, ST_FETCH, 'h2F0,  0, 16'h0F0F};
        tbl[7]  = '{0, 1, 0, 0, 1, 16'h1111, 10'h000, ST_EXEC,  'h2F1,  1, 16'h1111};
        tbl[8]  = '{0, 0, 0, 1, 0, 16'h0000, 10'h3FF, ST_FETCH, 'h3FF,  0, 16'h1111};
        tbl[9]  = '{0, 1, 0, 0, 0, 16'h2222, 10'h000, ST_EXEC,  0,      1, 16'h2222};
        tbl[10] = '{0, 0, 1, 1, 1, 16'h0000, 10'h055, ST_HALT,  0,      0, 16'h2222};
        tbl[11] = '{1, 1, 1, 1, 0, 16'h7777, 10'h066, ST_HALT,  0,      0, 16'h2222};

        idle_inputs();
        repeat (2) @(posedge CLK);
        #1;

        // ---- reset state ----
        do_reset("reset");
        chk("reset.state_const", state_o, ST_IDLE);
        chk("reset.pc_const",    pc,      RP);

        // ---- table ----
        for (int i = 0; i < 12; i++) begin
            start = tbl[i].st; mem_ack = tbl[i].ack; next = tbl[i].nx;
            branch = tbl[i].br; halt = tbl[i].hl;
            mem_rdata = tbl[i].rdata; branch_addr = tbl[i].baddr;
            model_edge();
            @(posedge CLK);
            #1;
            chk($sformatf("vec%0d.state", i),   state_o,  tbl[i].e_st);
            chk($sformatf("vec%0d.pc", i),      pc,       tbl[i].e_pc);
            chk($sformatf("vec%0d.addr", i),    mem_addr, tbl[i].e_pc);
            chk($sformatf("vec%0d.ir_w", i),    ir_w,     tbl[i].e_irw);
            chk($sformatf("vec%0d.ir_data", i), ir_data,  tbl[i].e_ir);
            chk($sformatf("vec%0d.mem_req", i), mem_req,  (tbl[i].e_st == ST_FETCH) ? 1 : 0);
            $display("vec %0d: state=%0d pc=%03h ir=%04h ir_w=%0b", i, state_o, pc, ir_data, ir_w);
        end
        idle_inputs();

        // ---- reset in FETCH with ack in the same cycle ----
        do_reset("rst2");
        start = 1; step("rfetch.enter"); start = 0;
        RESET = 1; mem_ack = 1; mem_rdata = 16'hBEEF;
        step("rfetch.reset");
        chk("rfetch.ir_data_zero", ir_data, 0);
        chk("rfetch.pc_reset",     pc,      RP);
        RESET = 0;
        step("rfetch.stale_ack1");
        step("rfetch.stale_ack2");
        chk("rfetch.still_idle", state_o, ST_IDLE);
        $display("reset-in-fetch: state=%0d ir=%04h pc=%03h", state_o, ir_data, pc);
        idle_inputs();

        // ---- RESET raised between edges must not act until the edge ----
        start = 1; step("async.enter"); start = 0;
        #2 RESET = 1;
        #1;
        chk("async.hold_state",   state_o, ST_FETCH);
        chk("async.hold_mem_req", mem_req, 1);
        step("async.edge");
        $display("async-hold: state=%0d after edge", state_o);
        idle_inputs();

        // ---- timeout / indefinite wait ----
        do_reset("rst3");
        start = 1; step("tmo.enter"); start = 0;
`ifdef FETCH_TIMEOUT_EN
        for (int k = 1; k <= 15; k++) step($sformatf("tmo.wait%0d", k));
        chk("tmo.still_fetch_at15", state_o, ST_FETCH);
        step("tmo.edge16");
        chk("tmo.error_state", state_o, ST_ERR);
        chk("tmo.err_flag",    err,     1);
        chk("tmo.mem_req_low", mem_req, 0);
`else
        for (int k = 1; k <= 40; k++) step($sformatf("tmo.wait%0d", k));
        chk("tmo.still_fetch", state_o, ST_FETCH);
        chk("tmo.mem_req_hi",  mem_req, 1);
        chk("tmo.err_low",     err,     0);
`endif
        $display("timeout: state=%0d err=%0b mem_req=%0b", state_o, err, mem_req);
        // late ack / start must not leave ERROR (and completes FETCH otherwise)
        mem_ack = 1; start = 1; mem_rdata = 16'h4321;
        step("tmo.late_ack");
        idle_inputs();

        // ---- randomized run ----
        do_reset("rst4");
        for (int n = 0; n < 3000; n++) begin
            RESET       = ($urandom_range(0, 99) == 0);
            start       = ($urandom_range(0, 3) == 0);
            mem_ack     = ($urandom_range(0, 2) == 0);
            mem_rdata   = 16'($urandom);
            next        = ($urandom_range(0, 2) == 0);
            branch      = ($urandom_range(0, 4) == 0);
            halt        = ($urandom_range(0, 39) == 0);
            branch_addr = 10'($urandom);
            step("rand");
            if (n % 250 == 0)
                $display("rand %0d: state=%0d pc=%03h ir=%04h", n, state_o, pc, ir_data);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
